// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared codes for the multi-cycle MIPS controller: instruction types, states, datapath selects.
// Pure declarations, no logic; imported by the controller and its output decoder.
// The ALU-control helper is the single place that maps an instruction type to ALU settings.
package mc_ctrl_fsm_pkg;

  // Decoded instruction types (InstrType)
  localparam logic [5:0] IT_ADDU = 6'd0;
  localparam logic [5:0] IT_SUBU = 6'd1;
  localparam logic [5:0] IT_ORI  = 6'd2;
  localparam logic [5:0] IT_LW   = 6'd3;
  localparam logic [5:0] IT_SW   = 6'd4;
  localparam logic [5:0] IT_BEQ  = 6'd5;
  localparam logic [5:0] IT_LUI  = 6'd6;
  localparam logic [5:0] IT_J    = 6'd7;
  localparam logic [5:0] IT_JAL  = 6'd8;
  localparam logic [5:0] IT_JR   = 6'd9;
  localparam logic [5:0] IT_SLL  = 6'd10;
  localparam logic [5:0] IT_ERR  = 6'd11;

  // Controller states; codes 5..7 are unreachable
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // PC source select
  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_RS  = 2'd3;

  // GRF destination select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // GRF write-data select
  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC  = 2'd2;

  // ALU operations
  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_OR  = 3'd2;
  localparam logic [2:0] ALUOP_LUI = 3'd3;
  localparam logic [2:0] ALUOP_SLL = 3'd4;

  typedef struct packed {
    logic [2:0] op;
    logic       src;
    logic       ext;
  } alu_ctl_t;

  // ALU settings used in EXEC and re-driven in WB so the result stays stable
  function automatic alu_ctl_t alu_ctl(input logic [5:0] it);
    alu_ctl_t c;
    c = '0;
    case (it)
      IT_ADDU:      begin c.op = ALUOP_ADD; c.src = 1'b0; c.ext = 1'b0; end
      IT_SUBU:      begin c.op = ALUOP_SUB; c.src = 1'b0; c.ext = 1'b0; end
      IT_ORI:       begin c.op = ALUOP_OR;  c.src = 1'b1; c.ext = 1'b0; end
      IT_LUI:       begin c.op = ALUOP_LUI; c.src = 1'b1; c.ext = 1'b0; end
      IT_SLL:       begin c.op = ALUOP_SLL; c.src = 1'b0; c.ext = 1'b0; end
      IT_LW, IT_SW: begin c.op = ALUOP_ADD; c.src = 1'b1; c.ext = 1'b1; end
      IT_BEQ:       begin c.op = ALUOP_SUB; c.src = 1'b0; c.ext = 1'b1; end
      default:      c = '0;
    endcase
    return c;
  endfunction

  // Register-register types write rd; everything else written in WB goes to rt
  function automatic logic is_rtype(input logic [5:0] it);
    return (it == IT_ADDU) || (it == IT_SUBU) || (it == IT_SLL);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_out.sv
// Output decoder: every strobe and select of the controller from state, type and handshakes.
// Latency: purely combinational, no registers.
// Backpressure: strobes are gated by IReady in FETCH and DReady in MEM, so waits issue nothing.
module mc_ctrl_out
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [2:0] State,
  input  logic [5:0] InstrType,
  input  logic       Zero,
  input  logic       IReady,
  input  logic       DReady,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] PCSrc,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic       EXTOp,
  output logic       MemWr,
  output logic       InstrDone,
  output logic       Illegal
);

  alu_ctl_t ctl;

  // Decode all outputs; everything defaults to 0 so unlisted cases issue no writes
  always_comb begin
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    PCSrc     = PCSRC_PC4;
    RegWr     = 1'b0;
    RegDst    = REGDST_RT;
    WDSel     = WDSEL_ALU;
    ALUSrc    = 1'b0;
    ALUOp     = ALUOP_ADD;
    EXTOp     = 1'b0;
    MemWr     = 1'b0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    ctl       = alu_ctl(InstrType);
    case (State)
      S_FETCH: begin
        if (IReady) begin
          IRWr  = 1'b1;
          PCWr  = 1'b1;
          PCSrc = PCSRC_PC4;
        end
      end
      S_DECODE: begin
        case (InstrType)
          IT_J: begin
            PCWr      = 1'b1;
            PCSrc     = PCSRC_J;
            InstrDone = 1'b1;
          end
          IT_JAL: begin
            // PC already holds old PC+4, so it lands in $31 on this same edge
            PCWr      = 1'b1;
            PCSrc     = PCSRC_J;
            RegWr     = 1'b1;
            RegDst    = REGDST_RA;
            WDSel     = WDSEL_PC;
            InstrDone = 1'b1;
          end
          IT_JR: begin
            PCWr      = 1'b1;
            PCSrc     = PCSRC_RS;
            InstrDone = 1'b1;
          end
          IT_ERR: Illegal = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        ALUOp  = ctl.op;
        ALUSrc = ctl.src;
        EXTOp  = ctl.ext;
        if (InstrType == IT_BEQ) begin
          PCWr      = Zero;
          PCSrc     = PCSRC_BR;
          InstrDone = 1'b1;
        end
      end
      S_MEM: begin
        // Address stays base + sign-extended offset for the whole wait
        ALUOp  = ALUOP_ADD;
        ALUSrc = 1'b1;
        EXTOp  = 1'b1;
        if (DReady && (InstrType == IT_SW)) begin
          MemWr     = 1'b1;
          InstrDone = 1'b1;
        end
      end
      S_WB: begin
        ALUOp     = ctl.op;
        ALUSrc    = ctl.src;
        EXTOp     = ctl.ext;
        RegWr     = 1'b1;
        InstrDone = 1'b1;
        RegDst    = is_rtype(InstrType) ? REGDST_RD : REGDST_RT;
        WDSel     = (InstrType == IT_LW) ? WDSEL_MEM : WDSEL_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: state register, next-state logic, retired-instruction count.
// Latency: 2..5 cycles per instruction at zero wait; outputs combinational from state and inputs.
// Backpressure: holds in FETCH while IReady=0 and in MEM while DReady=0, one cycle per wait cycle.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  InstrType,
  input  logic        Zero,
  input  logic        IReady,
  input  logic        DReady,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  PCSrc,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        EXTOp,
  output logic        MemWr,
  output logic [2:0]  State,
  output logic        InstrDone,
  output logic        Illegal,
  output logic [31:0] InstrCnt
);

  state_t state_q;
  state_t state_d;
  logic   instr_done;

  mc_ctrl_out u_out (
    .State     (state_q),
    .InstrType (InstrType),
    .Zero      (Zero),
    .IReady    (IReady),
    .DReady    (DReady),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .PCSrc     (PCSrc),
    .RegWr     (RegWr),
    .RegDst    (RegDst),
    .WDSel     (WDSel),
    .ALUSrc    (ALUSrc),
    .ALUOp     (ALUOp),
    .EXTOp     (EXTOp),
    .MemWr     (MemWr),
    .InstrDone (instr_done),
    .Illegal   (Illegal)
  );

  assign State     = state_q;
  assign InstrDone = instr_done;

  // Next state; unreachable codes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = IReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (InstrType)
          IT_J, IT_JAL, IT_JR, IT_ERR: state_d = S_FETCH;
          default:                     state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (InstrType)
          IT_BEQ:       state_d = S_FETCH;
          IT_LW, IT_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (!DReady)                state_d = S_MEM;
        else if (InstrType == IT_SW) state_d = S_FETCH;
        else                        state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           InstrCnt <= 32'd0;
    else if (instr_done) InstrCnt <= InstrCnt + 32'd1;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle traces built from the instruction rules.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Handshake inputs are randomized wherever the controller is required to ignore them.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3, ST_WB = 4;

  logic        clk, reset;
  logic [5:0]  InstrType;
  logic        Zero, IReady, DReady;
  logic        PCWr, IRWr, RegWr, ALUSrc, EXTOp, MemWr, InstrDone, Illegal;
  logic [1:0]  PCSrc, RegDst, WDSel;
  logic [2:0]  ALUOp, State;
  logic [31:0] InstrCnt;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .InstrType(InstrType), .Zero(Zero), .IReady(IReady),
    .DReady(DReady), .PCWr(PCWr), .IRWr(IRWr), .PCSrc(PCSrc), .RegWr(RegWr),
    .RegDst(RegDst), .WDSel(WDSel), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp),
    .MemWr(MemWr), .State(State), .InstrDone(InstrDone), .Illegal(Illegal),
    .InstrCnt(InstrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         st;
    logic [5:0] it;
    logic       ire, dre, zero;
    logic       pcwr, irwr, regwr, alusrc, extop, memwr, done, ill;
    logic [1:0] pcsrc, regdst, wdsel;
    logic [2:0] aluop;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model_cnt = 0;
  int          ran, n_memwr, n_ill, n_regwr;

  function automatic exp_t blank(input int st, input logic [5:0] it);
    exp_t e;
    e.st = st;
    e.it = (st == ST_FETCH) ? 6'($urandom_range(0, 63)) : it;
    e.ire = 1'($urandom_range(0, 1));
    e.dre = 1'($urandom_range(0, 1));
    e.zero = 1'($urandom_range(0, 1));
    e.pcwr = 0; e.irwr = 0; e.regwr = 0; e.alusrc = 0; e.extop = 0;
    e.memwr = 0; e.done = 0; e.ill = 0;
    e.pcsrc = 0; e.regdst = 0; e.wdsel = 0; e.aluop = 0;
    return e;
  endfunction

  // ALU settings table: {op, src, ext}
  function automatic logic [4:0] alu_of(input logic [5:0] it);
    if (it == IT_ADDU) return {3'd0, 1'b0, 1'b0};
    if (it == IT_SUBU) return {3'd1, 1'b0, 1'b0};
    if (it == IT_ORI)  return {3'd2, 1'b1, 1'b0};
    if (it == IT_LUI)  return {3'd3, 1'b1, 1'b0};
    if (it == IT_SLL)  return {3'd4, 1'b0, 1'b0};
    if (it == IT_LW || it == IT_SW) return {3'd0, 1'b1, 1'b1};
    if (it == IT_BEQ)  return {3'd1, 1'b0, 1'b1};
    return 5'd0;
  endfunction

  // Append the expected cycle-by-cycle trace of one instruction
  task automatic build(input logic [5:0] it, input int iw, input int dw, input logic z);
    exp_t e;
    logic [4:0] a;
    a = alu_of(it);
    for (int i = 0; i < iw; i++) begin
      e = blank(ST_FETCH, it); e.ire = 0; exp_q.push_back(e);
    end
    e = blank(ST_FETCH, it); e.ire = 1; e.irwr = 1; e.pcwr = 1; exp_q.push_back(e);
    e = blank(ST_DECODE, it);
    if (it == IT_J || it == IT_JAL || it == IT_JR) begin
      e.pcwr = 1; e.done = 1; e.pcsrc = (it == IT_JR) ? 2'd3 : 2'd2;
      if (it == IT_JAL) begin e.regwr = 1; e.regdst = 2; e.wdsel = 2; end
      exp_q.push_back(e); return;
    end
    if (it == IT_ERR) begin e.ill = 1; exp_q.push_back(e); return; end
    exp_q.push_back(e);
    e = blank(ST_EXEC, it); e.zero = z;
    {e.aluop, e.alusrc, e.extop} = a;
    if (it == IT_BEQ) begin
      e.pcwr = z; e.pcsrc = 1; e.done = 1; exp_q.push_back(e); return;
    end
    exp_q.push_back(e);
    if (it == IT_LW || it == IT_SW) begin
      for (int i = 0; i <= dw; i++) begin
        e = blank(ST_MEM, it); e.dre = (i == dw);
        e.aluop = 0; e.alusrc = 1; e.extop = 1;
        if (i == dw && it == IT_SW) begin e.memwr = 1; e.done = 1; end
        exp_q.push_back(e);
      end
      if (it == IT_SW) return;
    end
    e = blank(ST_WB, it);
    {e.aluop, e.alusrc, e.extop} = a;
    e.regwr = 1; e.done = 1;
    e.regdst = (it == IT_ADDU || it == IT_SUBU || it == IT_SLL) ? 2'd1 : 2'd0;
    e.wdsel = (it == IT_LW) ? 2'd1 : 2'd0;
    exp_q.push_back(e);
  endtask

  // Play up to 'limit' queued cycles; called and returns at posedge+1
  task automatic run_trace(input string name, input int limit);
    exp_t e;
    logic [16:0] obs, want;
    ran = 0; n_memwr = 0; n_ill = 0; n_regwr = 0;
    while (exp_q.size() > 0 && ran < limit) begin
      e = exp_q.pop_front();
      InstrType = e.it; IReady = e.ire; DReady = e.dre; Zero = e.zero;
      @(negedge clk);
      obs  = {PCWr, IRWr, PCSrc, RegWr, RegDst, WDSel, ALUSrc, ALUOp, EXTOp, MemWr, InstrDone, Illegal};
      want = {e.pcwr, e.irwr, e.pcsrc, e.regwr, e.regdst, e.wdsel, e.alusrc, e.aluop,
              e.extop, e.memwr, e.done, e.ill};
      n_chk++;
      if (State !== 3'(e.st)) begin
        n_err++; $display("FAIL %s state cyc%0d: got %0d want %0d", name, ran, State, e.st);
      end
      n_chk++;
      if (obs !== want) begin
        n_err++; $display("FAIL %s outputs cyc%0d: got %b want %b", name, ran, obs, want);
      end
      n_chk++;
      if (InstrCnt !== model_cnt) begin
        n_err++; $display("FAIL %s instrcnt cyc%0d: got %0d want %0d", name, ran, InstrCnt, model_cnt);
      end
      if (MemWr === 1'b1) n_memwr++;
      if (Illegal === 1'b1) n_ill++;
      if (RegWr === 1'b1) n_regwr++;
      if (e.done) model_cnt++;
      ran++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1; InstrType = 0; Zero = 0; IReady = 0; DReady = 0;
    #3;
    n_chk++;
    if ({State, PCWr, IRWr, PCSrc, RegWr, RegDst, WDSel, ALUSrc, ALUOp, EXTOp, MemWr,
         InstrDone, Illegal} !== 20'd0 || InstrCnt !== 0) begin
      n_err++; $display("FAIL reset_state: got state %0d cnt %0d, want all 0", State, InstrCnt);
    end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    model_cnt = 0;
  endtask

  task automatic test_addu;
    logic [31:0] c0;
    c0 = model_cnt;
    build(IT_ADDU, 0, 0, 1'($urandom_range(0, 1)));
    run_trace("addu", 100);
    n_chk++;
    if (ran != 4 || n_regwr != 1 || InstrCnt !== c0 + 1) begin
      n_err++; $display("FAIL addu_len: got %0d cyc %0d regwr cnt %0d, want 4 cyc 1 regwr cnt %0d",
                        ran, n_regwr, InstrCnt, c0 + 1);
    end
  endtask

  task automatic test_lw_wait;
    build(IT_LW, 0, 3, 1'b0);
    run_trace("lw_wait", 100);
    n_chk++;
    if (ran != 8 || n_memwr != 0) begin
      n_err++; $display("FAIL lw_wait: got %0d cyc %0d memwr, want 8 cyc 0 memwr", ran, n_memwr);
    end
  endtask

  task automatic test_beq;
    build(IT_BEQ, 0, 0, 1'b1);
    build(IT_BEQ, 0, 0, 1'b0);
    run_trace("beq", 100);
    n_chk++;
    if (ran != 6) begin
      n_err++; $display("FAIL beq_len: got %0d cycles want 6", ran);
    end
  endtask

  task automatic test_jal;
    build(IT_JAL, 0, 0, 1'b0);
    run_trace("jal", 100);
    n_chk++;
    if (ran != 2 || n_regwr != 1) begin
      n_err++; $display("FAIL jal_len: got %0d cyc %0d regwr want 2 cyc 1 regwr", ran, n_regwr);
    end
  endtask

  task automatic test_err_sw;
    logic [31:0] c0;
    c0 = model_cnt;
    build(IT_ERR, 0, 0, 1'b0);
    build(IT_SW, 0, 0, 1'b0);
    run_trace("err_sw", 100);
    n_chk++;
    if (ran != 6 || n_ill != 1 || n_memwr != 1 || InstrCnt !== c0 + 1) begin
      n_err++; $display("FAIL err_sw: got cyc %0d ill %0d memwr %0d cnt %0d want 6 1 1 %0d",
                        ran, n_ill, n_memwr, InstrCnt, c0 + 1);
    end
  endtask

  task automatic test_random;
    logic [5:0] types[11];
    logic [31:0] c0;
    int retired;
    types = '{IT_ADDU, IT_SUBU, IT_ORI, IT_LW, IT_SW, IT_BEQ, IT_LUI, IT_J, IT_JAL, IT_JR, IT_ERR};
    c0 = model_cnt; retired = 0;
    for (int i = 0; i < 60; i++) begin
      logic [5:0] t;
      t = types[$urandom_range(0, 10)];
      if (i % 7 == 3) t = IT_SLL;
      if (t != IT_ERR) retired++;
      build(t, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      run_trace("random", 100);
    end
    n_chk++;
    if (InstrCnt !== c0 + 32'(retired)) begin
      n_err++; $display("FAIL random_total: got cnt %0d want %0d", InstrCnt, c0 + 32'(retired));
    end
  endtask

  task automatic test_reset_mid_mem;
    // sw with 1 fetch wait: FETCH x2, DECODE, EXEC, MEM x2 played, still waiting in MEM
    build(IT_SW, 1, 5, 1'b0);
    run_trace("rst_pre", 6);
    exp_q.delete();
    IReady = 0; DReady = 1; InstrType = IT_SW;
    #2 reset = 1;
    #1;
    n_chk++;
    if (State !== 3'd0 || MemWr !== 1'b0 || InstrCnt !== 32'd0 || InstrDone !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_mem: got state %0d memwr %b cnt %0d, want 0 0 0",
                        State, MemWr, InstrCnt);
    end
    @(negedge clk); DReady = 0;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    model_cnt = 0;
    build(IT_ORI, 0, 0, 1'b1);
    run_trace("after_rst", 100);
    n_chk++;
    if (ran != 4 || InstrCnt !== 32'd1) begin
      n_err++; $display("FAIL after_reset: got %0d cyc cnt %0d want 4 cyc cnt 1", ran, InstrCnt);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_err_sw();
    test_random();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
